// File: rtl/aes_pkg.sv
// Shared AES controller definitions: block/key-index widths, standard Nr/Nk pairs
// and the sequencer state encoding.
package aes_pkg;

  localparam int BLOCK_W  = 128;
  localparam int RK_IDX_W = 4;

  localparam int NR_AES128 = 10;
  localparam int NK_AES128 = 4;
  localparam int NR_AES192 = 12;
  localparam int NK_AES192 = 6;
  localparam int NR_AES256 = 14;
  localparam int NK_AES256 = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the state register, walks round keys Nr..0
// through external round/final logic. Latency Nr cycles accept->m_valid; no skid, s_ready low while busy.
module aes_decrypt_ctrl
  import aes_pkg::*;
#(
  parameter int Nr = NR_AES128,
  parameter int Nk = NK_AES128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_ready,
  input  logic                abort,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BLOCK_W-1:0]  s_block,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BLOCK_W-1:0]  m_block,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [BLOCK_W-1:0]  rk_data,
  output logic [BLOCK_W-1:0]  rnd_state_o,
  input  logic [BLOCK_W-1:0]  rnd_state_i,
  output logic [BLOCK_W-1:0]  fin_state_o,
  input  logic [BLOCK_W-1:0]  fin_state_i,
  output logic                busy
);

  localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(Nr);
  localparam logic [RK_IDX_W-1:0] NR_M1  = RK_IDX_W'(Nr - 1);

  ctrl_state_t         r_state;
  logic [RK_IDX_W-1:0] r_cnt;
  logic [BLOCK_W-1:0]  r_state_reg;
  logic [BLOCK_W-1:0]  r_out_reg;
  logic                r_armed;
  logic                w_accept;

  // r_armed keeps s_ready low until the first edge after reset release
  assign s_ready     = r_armed & (r_state == IDLE) & key_ready & ~abort;
  assign w_accept    = s_valid & s_ready;
  assign busy        = (r_state != IDLE);
  assign m_valid     = (r_state == DONE);
  assign m_block     = r_out_reg;
  assign rnd_state_o = r_state_reg;
  assign fin_state_o = r_state_reg;

  always_comb begin
    rk_idx = '0;
    case (r_state)
      IDLE:    rk_idx = NR_IDX;
      ROUND:   rk_idx = r_cnt;
      default: rk_idx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_state_reg <= '0;
      r_out_reg   <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (abort) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_state_reg <= '0;
        r_out_reg   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_state_reg <= s_block ^ rk_data;
              r_cnt       <= NR_M1;
              r_state     <= ROUND;
            end
          end
          ROUND: begin
            r_state_reg <= rnd_state_i;
            if (r_cnt == RK_IDX_W'(1)) begin
              r_state <= FINAL;
            end else begin
              r_cnt <= r_cnt - RK_IDX_W'(1);
            end
          end
          FINAL: begin
            r_out_reg <= fin_state_i ^ rk_data;
            r_state   <= DONE;
          end
          DONE: begin
            if (m_ready) begin
              r_state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  // AES always pairs Nr with Nk+6; a mismatch means the key store is sized wrong
  a_nr_nk: assert property (@(posedge clk) disable iff (!rst_n) Nr == Nk + 6);

endmodule
